// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with write-to-read bypass, optional zero register and per-register pending scoreboard
//   clock/reset            : single clock, asynchronous active-high reset clearing registers and pending bits
//   Read1/Read2            : combinational read indices -> Data1/Data2 (bypassed), Busy1/Busy2 (unresolved pending)
//   WriteReg/WriteData/RegWrite : clocked write port; a write also resolves the pending bit
//   Issue/IssueReg         : marks a register pending when its producer issues
//   AnyPending/PendCount   : registered summary of the pending vector
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Read1,
  input  logic [ADDR_WIDTH-1:0] Read2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  input  logic                  Issue,
  input  logic [ADDR_WIDTH-1:0] IssueReg,
  output logic [DATA_WIDTH-1:0] Data1,
  output logic [DATA_WIDTH-1:0] Data2,
  output logic                  Busy1,
  output logic                  Busy2,
  output logic                  AnyPending,
  output logic [ADDR_WIDTH:0]   PendCount
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DATA_WIDTH-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic any_q, any_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic wr_ok, is_ok, hit1, hit2, z1, z2;
  always_comb begin
    wr_ok = RegWrite && !(ZERO_REG && WriteReg == '0);
    is_ok = Issue && !(ZERO_REG && IssueReg == '0);
    rf_d = rf_q;
    pend_d = pend_q;
    if (wr_ok) begin
      rf_d[WriteReg] = WriteData;
      pend_d[WriteReg] = 1'b0;
    end
    // issue is applied after the write so a same-index new producer wins
    if (is_ok) pend_d[IssueReg] = 1'b1;
    any_d = |pend_d;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + (ADDR_WIDTH+1)'(pend_d[i]);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_q <= '{default: '0};
      pend_q <= '0;
      any_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rf_q <= rf_d;
      pend_q <= pend_d;
      any_q <= any_d;
      cnt_q <= cnt_d;
    end
  end
  // reads are gated by reset so a bypass strobe cannot leak data while clearing
  always_comb begin
    z1 = ZERO_REG && Read1 == '0;
    z2 = ZERO_REG && Read2 == '0;
    hit1 = RegWrite && WriteReg == Read1;
    hit2 = RegWrite && WriteReg == Read2;
    Data1 = (reset || z1) ? '0 : hit1 ? WriteData : rf_q[Read1];
    Data2 = (reset || z2) ? '0 : hit2 ? WriteData : rf_q[Read2];
    Busy1 = !reset && !z1 && pend_q[Read1] && !hit1;
    Busy2 = !reset && !z2 && pend_q[Read2] && !hit2;
  end
  assign AnyPending = any_q;
  assign PendCount = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus with a queue-based scoreboard and a decoupled monitor
module tb_regfile_scoreboard;
  logic clock, reset, RegWrite, Issue, Busy1, Busy2, AnyPending;
  logic [4:0] Read1, Read2, WriteReg, IssueReg;
  logic [63:0] WriteData, Data1, Data2;
  logic [5:0] PendCount;
  typedef struct {
    string name;
    int sel;
    logic [63:0] exp;
  } exp_t;
  exp_t q[$];
  event sample_ev;
  int pass_cnt = 0;
  int total_cnt = 0;
  regfile_scoreboard dut (
    .clock(clock), .reset(reset), .Read1(Read1), .Read2(Read2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .Issue(Issue), .IssueReg(IssueReg), .Data1(Data1), .Data2(Data2),
    .Busy1(Busy1), .Busy2(Busy2), .AnyPending(AnyPending), .PendCount(PendCount)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [63:0] actual(input int s);
    case (s)
      0: return Data1;
      1: return Data2;
      2: return {63'd0, Busy1};
      3: return {63'd0, Busy2};
      4: return {63'd0, AnyPending};
      default: return {58'd0, PendCount};
    endcase
  endfunction
  always begin
    @(sample_ev);
    #1;
    while (q.size() != 0) begin
      exp_t e;
      logic [63:0] a;
      e = q.pop_front();
      a = actual(e.sel);
      total_cnt++;
      if (a === e.exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
    end
  end
  task automatic chk(input string n, input int s, input logic [63:0] e);
    exp_t x;
    x.name = n;
    x.sel = s;
    x.exp = e;
    q.push_back(x);
  endtask
  task automatic fire();
    -> sample_ev;
    #2;
  endtask
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask
  initial begin
    reset = 1'b1;
    RegWrite = 1'b0;
    Issue = 1'b0;
    Read1 = '0;
    Read2 = '0;
    WriteReg = '0;
    IssueReg = '0;
    WriteData = '0;
    @(negedge clock);
    chk("rst_any", 4, 0);
    chk("rst_cnt", 5, 0);
    fire();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      Read1 = 5'(i);
      Read2 = 5'(31 - i);
      chk($sformatf("init_d1_r%0d", i), 0, 0);
      chk($sformatf("init_d2_r%0d", 31 - i), 1, 0);
      chk($sformatf("init_b1_r%0d", i), 2, 0);
      chk($sformatf("init_b2_r%0d", 31 - i), 3, 0);
      fire();
    end
    chk("init_any", 4, 0);
    chk("init_cnt", 5, 0);
    fire();
    step();
    RegWrite = 1'b1;
    WriteReg = 5;
    WriteData = 64'hDEADBEEF_00000001;
    Read1 = 5;
    chk("bypass_r5", 0, 64'hDEADBEEF_00000001);
    fire();
    step();
    RegWrite = 1'b0;
    chk("array_r5", 0, 64'hDEADBEEF_00000001);
    chk("array_r5_busy", 2, 0);
    fire();
    RegWrite = 1'b1;
    WriteReg = 0;
    WriteData = '1;
    Issue = 1'b1;
    IssueReg = 0;
    Read1 = 0;
    chk("zero_bypass", 0, 0);
    fire();
    step();
    RegWrite = 1'b0;
    Issue = 1'b0;
    chk("zero_data", 0, 0);
    chk("zero_busy", 2, 0);
    chk("zero_cnt", 5, 0);
    chk("zero_any", 4, 0);
    fire();
    Issue = 1'b1;
    IssueReg = 3;
    Read2 = 3;
    chk("iss3_same_busy", 3, 0);
    chk("iss3_same_cnt", 5, 0);
    fire();
    step();
    IssueReg = 7;
    chk("iss3_busy", 3, 1);
    chk("iss3_cnt", 5, 1);
    chk("iss3_any", 4, 1);
    fire();
    step();
    Issue = 1'b0;
    chk("iss7_cnt", 5, 2);
    fire();
    RegWrite = 1'b1;
    WriteReg = 3;
    WriteData = 64'h33;
    chk("wr3_busy2", 3, 0);
    chk("wr3_data2", 1, 64'h33);
    chk("wr3_cnt_hold", 5, 2);
    fire();
    step();
    RegWrite = 1'b0;
    Read1 = 7;
    chk("wr3_cnt", 5, 1);
    chk("wr3_busy2_after", 3, 0);
    chk("r7_busy1", 2, 1);
    fire();
    RegWrite = 1'b1;
    WriteReg = 7;
    WriteData = 64'h77;
    chk("wr7_busy1", 2, 0);
    fire();
    step();
    RegWrite = 1'b0;
    chk("wr7_cnt", 5, 0);
    chk("wr7_any", 4, 0);
    chk("wr7_data1", 0, 64'h77);
    fire();
    Issue = 1'b1;
    IssueReg = 9;
    RegWrite = 1'b1;
    WriteReg = 9;
    WriteData = 64'h42;
    step();
    Issue = 1'b0;
    RegWrite = 1'b0;
    Read1 = 9;
    Read2 = 9;
    chk("r9_d1", 0, 64'h42);
    chk("r9_d2", 1, 64'h42);
    chk("r9_b1", 2, 1);
    chk("r9_b2", 3, 1);
    chk("r9_cnt", 5, 1);
    fire();
    Issue = 1'b1;
    IssueReg = 4;
    RegWrite = 1'b1;
    WriteReg = 2;
    WriteData = 64'h22;
    Read1 = 2;
    Read2 = 4;
    chk("r2_bypass", 0, 64'h22);
    chk("r4_same_busy", 3, 0);
    fire();
    step();
    chk("r4_busy", 3, 1);
    chk("pre_rst_cnt", 5, 2);
    chk("pre_rst_d1", 0, 64'h22);
    fire();
    #1;
    reset = 1'b1;
    chk("arst_d1", 0, 0);
    chk("arst_d2", 1, 0);
    chk("arst_b2", 3, 0);
    chk("arst_any", 4, 0);
    chk("arst_cnt", 5, 0);
    fire();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    Issue = 1'b0;
    RegWrite = 1'b0;
    chk("post_rst_r2", 0, 0);
    chk("post_rst_b2", 3, 0);
    chk("post_rst_cnt", 5, 0);
    fire();
    step();
    Read1 = 5;
    Read2 = 9;
    chk("post_rst_r5", 0, 0);
    chk("post_rst_r9", 1, 0);
    chk("post_rst_any", 4, 0);
    fire();
    #5;
    if (q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
